// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch unit bus bundle: PC, memory and decode sides (O_STALL_COUNT under CR16_FETCH_STALL_COUNT_EN)
interface fetch_if #(
   parameter int P_ADDRESS_WIDTH = 16,
   parameter int P_DATA_WIDTH    = 16
);
   logic [P_ADDRESS_WIDTH-1:0] I_PC_ADDRESS;
   logic                       O_PC_ENABLE;
   logic [P_ADDRESS_WIDTH-1:0] O_PC_ADDRESS;
   logic                       O_PC_ADDRESS_SELECT;
   logic                       O_PC_ADDRESS_SELECT_DISPLACE;
   logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS;
   logic                       O_MEM_READ;
   logic [P_DATA_WIDTH-1:0]    I_MEM_DATA;
   logic [P_DATA_WIDTH-1:0]    O_INSTR;
   logic                       O_INSTR_VALID;
   logic                       I_INSTR_READY;
   logic                       I_REDIRECT;
   logic [P_ADDRESS_WIDTH-1:0] I_REDIRECT_ADDRESS;
   logic                       I_REDIRECT_DISPLACE;
`ifdef CR16_FETCH_STALL_COUNT_EN
   logic [15:0]                O_STALL_COUNT;
`endif

   modport master (
      input  I_PC_ADDRESS, I_MEM_DATA, I_INSTR_READY, I_REDIRECT,
             I_REDIRECT_ADDRESS, I_REDIRECT_DISPLACE,
`ifdef CR16_FETCH_STALL_COUNT_EN
      output O_STALL_COUNT,
`endif
      output O_PC_ENABLE, O_PC_ADDRESS, O_PC_ADDRESS_SELECT,
             O_PC_ADDRESS_SELECT_DISPLACE, O_MEM_ADDRESS, O_MEM_READ,
             O_INSTR, O_INSTR_VALID
   );

   modport slave (
      output I_PC_ADDRESS, I_MEM_DATA, I_INSTR_READY, I_REDIRECT,
             I_REDIRECT_ADDRESS, I_REDIRECT_DISPLACE,
`ifdef CR16_FETCH_STALL_COUNT_EN
      input  O_STALL_COUNT,
`endif
      input  O_PC_ENABLE, O_PC_ADDRESS, O_PC_ADDRESS_SELECT,
             O_PC_ADDRESS_SELECT_DISPLACE, O_MEM_ADDRESS, O_MEM_READ,
             O_INSTR, O_INSTR_VALID
   );
endinterface

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch FSM: issue, capture, hold for decode, advance or redirect PC
// Optional stall counter output enabled by defining CR16_FETCH_STALL_COUNT_EN.
module fetch #(
   parameter int P_ADDRESS_WIDTH = 16,
   parameter int P_DATA_WIDTH    = 16
) (
   input  logic    I_CLK,
   input  logic    I_NRESET,
   fetch_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_CAPTURE, S_HOLD, S_ADVANCE, S_REDIRECT
   } state_t;

   state_t                     state_q, state_d;
   logic [P_ADDRESS_WIDTH-1:0] redir_addr_q;
   logic                       redir_disp_q;
   logic [P_DATA_WIDTH-1:0]    instr_q;
   logic                       instr_valid_q;
   logic                       take_redirect;

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state_q       <= S_IDLE;
         redir_addr_q  <= '0;
         redir_disp_q  <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_valid_q <= (state_d == S_HOLD);
         if (take_redirect) begin
            redir_addr_q <= bus.I_REDIRECT_ADDRESS;
            redir_disp_q <= bus.I_REDIRECT_DISPLACE;
         end
         // Data is captured only on the way to HOLD so a redirect drops it.
         if (state_q == S_CAPTURE && state_d == S_HOLD)
            instr_q <= bus.I_MEM_DATA;
      end
   end

   always_comb begin
      state_d                          = state_q;
      take_redirect                    = 1'b0;
      bus.O_MEM_READ                   = 1'b0;
      bus.O_MEM_ADDRESS                = '0;
      bus.O_PC_ENABLE                  = 1'b0;
      bus.O_PC_ADDRESS_SELECT          = 1'b0;
      bus.O_PC_ADDRESS                 = '0;
      bus.O_PC_ADDRESS_SELECT_DISPLACE = 1'b0;
      bus.O_INSTR                      = instr_q;
      bus.O_INSTR_VALID                = instr_valid_q;
      case (state_q)
         S_IDLE: state_d = S_ISSUE;
         S_ISSUE: begin
            bus.O_MEM_READ    = 1'b1;
            bus.O_MEM_ADDRESS = bus.I_PC_ADDRESS;
            take_redirect     = bus.I_REDIRECT;
            state_d           = bus.I_REDIRECT ? S_REDIRECT : S_CAPTURE;
         end
         S_CAPTURE: begin
            take_redirect = bus.I_REDIRECT;
            state_d       = bus.I_REDIRECT ? S_REDIRECT : S_HOLD;
         end
         S_HOLD: begin
            take_redirect = bus.I_REDIRECT;
            // Redirect wins over a same-cycle accept.
            if (bus.I_REDIRECT)
               state_d = S_REDIRECT;
            else if (bus.I_INSTR_READY)
               state_d = S_ADVANCE;
         end
         S_ADVANCE: begin
            bus.O_PC_ENABLE = 1'b1;
            state_d         = S_ISSUE;
         end
         S_REDIRECT: begin
            bus.O_PC_ENABLE                  = 1'b1;
            bus.O_PC_ADDRESS_SELECT          = 1'b1;
            bus.O_PC_ADDRESS                 = redir_addr_q;
            bus.O_PC_ADDRESS_SELECT_DISPLACE = redir_disp_q;
            state_d                          = S_ISSUE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef CR16_FETCH_STALL_COUNT_EN
   logic [15:0] stall_count_q;

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET)
         stall_count_q <= '0;
      else if (instr_valid_q && !bus.I_INSTR_READY && stall_count_q != 16'hFFFF)
         stall_count_q <= stall_count_q + 16'd1;
   end

   assign bus.O_STALL_COUNT = stall_count_q;
`endif
endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for fetch with memory/PC models and instruction scoreboard
module tb_fetch;
   logic clk = 1'b0;
   logic nreset = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   inc_pulses = 0;
   int   redir_pulses = 0;
   logic prev_en = 1'b0;
   logic [15:0] mem [0:255];
   logic [15:0] pc;
   logic [15:0] mem_data;
   logic [15:0] exp_q [$];
   int          accept_cyc [$];

   fetch_if #(.P_ADDRESS_WIDTH(16), .P_DATA_WIDTH(16)) bus ();

   fetch #(.P_ADDRESS_WIDTH(16), .P_DATA_WIDTH(16)) dut (
      .I_CLK    (clk),
      .I_NRESET (nreset),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Program counter and one-cycle-latency memory models
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pc       <= 16'h0000;
         mem_data <= 16'h0000;
      end else begin
         mem_data <= bus.O_MEM_READ ? mem[bus.O_MEM_ADDRESS[7:0]] : 16'hDEAD;
         if (bus.O_PC_ENABLE) begin
            if (!bus.O_PC_ADDRESS_SELECT)
               pc <= pc + 16'd1;
            else if (bus.O_PC_ADDRESS_SELECT_DISPLACE)
               pc <= pc + bus.O_PC_ADDRESS;
            else
               pc <= bus.O_PC_ADDRESS;
         end
      end
   end

   assign bus.I_PC_ADDRESS = pc;
   assign bus.I_MEM_DATA   = mem_data;

   // Monitor samples mid-low-phase, after inputs settle and before the next posedge.
   always begin
      @(negedge clk);
      #3;
      if (!nreset) begin
         prev_en = 1'b0;
      end else begin
         cyc++;
         total++;
         if (bus.O_PC_ENABLE && (prev_en || bus.O_MEM_READ)) begin
            bad++;
            $display("FAIL pc_enable_isolated: enable=%0b prev=%0b mem_read=%0b, required lone pulse outside ISSUE",
                     bus.O_PC_ENABLE, prev_en, bus.O_MEM_READ);
         end
         if (bus.O_PC_ENABLE) begin
            if (bus.O_PC_ADDRESS_SELECT) redir_pulses++;
            else inc_pulses++;
         end
         prev_en = bus.O_PC_ENABLE;
         if (bus.O_INSTR_VALID && bus.I_INSTR_READY && !bus.I_REDIRECT) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_accept: instr=%h, required no accept", bus.O_INSTR);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               accept_cyc.push_back(cyc);
               if (bus.O_INSTR !== e) begin
                  bad++;
                  $display("FAIL scoreboard_instr: got %h, required %h", bus.O_INSTR, e);
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      bus.I_INSTR_READY = 1'b0;
      bus.I_REDIRECT = 1'b0;
      bus.I_REDIRECT_ADDRESS = 16'h0000;
      bus.I_REDIRECT_DISPLACE = 1'b0;
      step();
      step();
      exp_q.delete();
      accept_cyc.delete();
      nreset = 1'b1;
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 20 && !bus.O_INSTR_VALID; i++) step();
      total++;
      if (!bus.O_INSTR_VALID) begin
         bad++;
         $display("FAIL %s_wait_valid: valid=%0b after 20 cycles, required 1", name, bus.O_INSTR_VALID);
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: %0d left, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      step();
      total++;
      if ({bus.O_PC_ENABLE, bus.O_PC_ADDRESS_SELECT, bus.O_PC_ADDRESS_SELECT_DISPLACE,
           bus.O_MEM_READ, bus.O_INSTR_VALID} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b, required 00000",
                  {bus.O_PC_ENABLE, bus.O_PC_ADDRESS_SELECT, bus.O_PC_ADDRESS_SELECT_DISPLACE,
                   bus.O_MEM_READ, bus.O_INSTR_VALID});
      end
      total++;
      if ({bus.O_PC_ADDRESS, bus.O_MEM_ADDRESS, bus.O_INSTR} !== 48'h0) begin
         bad++;
         $display("FAIL reset_buses: got %h, required 0", {bus.O_PC_ADDRESS, bus.O_MEM_ADDRESS, bus.O_INSTR});
      end
`ifdef CR16_FETCH_STALL_COUNT_EN
      total++;
      if (bus.O_STALL_COUNT !== 16'h0) begin
         bad++;
         $display("FAIL reset_stall_count: got %h, required 0000", bus.O_STALL_COUNT);
      end
`endif
   endtask

   task automatic test_first_fetch();
      bus.I_INSTR_READY = 1'b1;
      do_reset();
      exp_q.push_back(16'h1234);
      total++;
      if (bus.O_MEM_READ !== 1'b0) begin
         bad++; $display("FAIL first_idle_read: got %b, required 0", bus.O_MEM_READ);
      end
      bus.I_INSTR_READY = 1'b1;
      step();
      total++;
      if (bus.O_MEM_READ !== 1'b1 || bus.O_MEM_ADDRESS !== 16'h0000) begin
         bad++; $display("FAIL first_issue: read=%b addr=%h, required 1 0000", bus.O_MEM_READ, bus.O_MEM_ADDRESS);
      end
      step();
      total++;
      if (bus.O_MEM_READ !== 1'b0 || bus.O_INSTR_VALID !== 1'b0) begin
         bad++; $display("FAIL first_capture: read=%b valid=%b, required 0 0", bus.O_MEM_READ, bus.O_INSTR_VALID);
      end
      step();
      total++;
      if (bus.O_INSTR_VALID !== 1'b1 || bus.O_INSTR !== 16'h1234) begin
         bad++; $display("FAIL first_valid: valid=%b instr=%h, required 1 1234", bus.O_INSTR_VALID, bus.O_INSTR);
      end
      step();
      bus.I_INSTR_READY = 1'b0;
      total++;
      if (bus.O_PC_ENABLE !== 1'b1 || bus.O_PC_ADDRESS_SELECT !== 1'b0 || bus.O_INSTR_VALID !== 1'b0) begin
         bad++; $display("FAIL first_advance: en=%b sel=%b valid=%b, required 1 0 0",
                         bus.O_PC_ENABLE, bus.O_PC_ADDRESS_SELECT, bus.O_INSTR_VALID);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL first_popped: %0d left, required 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int inc0;
      do_reset();
      for (int i = 0; i < 6; i++) exp_q.push_back(mem[i]);
      inc0 = inc_pulses;
      bus.I_INSTR_READY = 1'b1;
      wait_drain("stream");
      bus.I_INSTR_READY = 1'b0;
      step();
      step();
      for (int i = 1; i < accept_cyc.size(); i++) begin
         total++;
         if (accept_cyc[i] - accept_cyc[i-1] != 4) begin
            bad++; $display("FAIL stream_spacing: %0d cycles, required 4", accept_cyc[i] - accept_cyc[i-1]);
         end
      end
      total++;
      if (inc_pulses - inc0 != 6 || pc !== 16'd6) begin
         bad++; $display("FAIL stream_pc: pulses=%0d pc=%h, required 6 0006", inc_pulses - inc0, pc);
      end
   endtask

   task automatic test_stall();
      int inc0;
      do_reset();
      exp_q.push_back(16'h1234);
      wait_valid("stall");
      inc0 = inc_pulses;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (bus.O_INSTR_VALID !== 1'b1 || bus.O_INSTR !== 16'h1234 || bus.O_PC_ENABLE !== 1'b0) begin
            bad++; $display("FAIL stall_hold: valid=%b instr=%h en=%b, required 1 1234 0",
                            bus.O_INSTR_VALID, bus.O_INSTR, bus.O_PC_ENABLE);
         end
         step();
      end
`ifdef CR16_FETCH_STALL_COUNT_EN
      total++;
      if (bus.O_STALL_COUNT !== 16'd5) begin
         bad++; $display("FAIL stall_count: got %0d, required 5", bus.O_STALL_COUNT);
      end
`endif
      total++;
      if (inc_pulses != inc0) begin
         bad++; $display("FAIL stall_no_pulse: %0d pulses, required 0", inc_pulses - inc0);
      end
      bus.I_INSTR_READY = 1'b1;
      wait_drain("stall");
      bus.I_INSTR_READY = 1'b0;
   endtask

   task automatic test_redirect_capture();
      int inc0, red0;
      bus.I_INSTR_READY = 1'b1;
      do_reset();
      bus.I_INSTR_READY = 1'b1;
      inc0 = inc_pulses;
      red0 = redir_pulses;
      step();
      step();
      bus.I_REDIRECT = 1'b1;
      bus.I_REDIRECT_ADDRESS = 16'h0040;
      bus.I_REDIRECT_DISPLACE = 1'b0;
      step();
      bus.I_REDIRECT = 1'b0;
      bus.I_REDIRECT_ADDRESS = 16'h0000;
      exp_q.push_back(mem[8'h40]);
      total++;
      if (bus.O_INSTR_VALID !== 1'b0 || bus.O_PC_ENABLE !== 1'b1 || bus.O_PC_ADDRESS_SELECT !== 1'b1 ||
          bus.O_PC_ADDRESS !== 16'h0040 || bus.O_PC_ADDRESS_SELECT_DISPLACE !== 1'b0) begin
         bad++; $display("FAIL redir_pulse: valid=%b en=%b sel=%b addr=%h disp=%b, required 0 1 1 0040 0",
                         bus.O_INSTR_VALID, bus.O_PC_ENABLE, bus.O_PC_ADDRESS_SELECT,
                         bus.O_PC_ADDRESS, bus.O_PC_ADDRESS_SELECT_DISPLACE);
      end
      step();
      total++;
      if (bus.O_MEM_READ !== 1'b1 || bus.O_MEM_ADDRESS !== 16'h0040) begin
         bad++; $display("FAIL redir_reissue: read=%b addr=%h, required 1 0040", bus.O_MEM_READ, bus.O_MEM_ADDRESS);
      end
      total++;
      if (inc_pulses != inc0 || redir_pulses != red0 + 1) begin
         bad++; $display("FAIL redir_counts: inc=%0d redir=%0d, required 0 1", inc_pulses - inc0, redir_pulses - red0);
      end
      wait_drain("redir");
      bus.I_INSTR_READY = 1'b0;
   endtask

   task automatic test_redirect_priority();
      int inc0, red0;
      do_reset();
      wait_valid("prio");
      inc0 = inc_pulses;
      red0 = redir_pulses;
      bus.I_INSTR_READY = 1'b1;
      bus.I_REDIRECT = 1'b1;
      bus.I_REDIRECT_ADDRESS = 16'hFFFE;
      bus.I_REDIRECT_DISPLACE = 1'b1;
      step();
      bus.I_INSTR_READY = 1'b0;
      bus.I_REDIRECT = 1'b0;
      bus.I_REDIRECT_DISPLACE = 1'b0;
      total++;
      if (bus.O_INSTR_VALID !== 1'b0 || bus.O_PC_ENABLE !== 1'b1 || bus.O_PC_ADDRESS_SELECT !== 1'b1 ||
          bus.O_PC_ADDRESS !== 16'hFFFE || bus.O_PC_ADDRESS_SELECT_DISPLACE !== 1'b1) begin
         bad++; $display("FAIL prio_pulse: valid=%b en=%b sel=%b addr=%h disp=%b, required 0 1 1 fffe 1",
                         bus.O_INSTR_VALID, bus.O_PC_ENABLE, bus.O_PC_ADDRESS_SELECT,
                         bus.O_PC_ADDRESS, bus.O_PC_ADDRESS_SELECT_DISPLACE);
      end
      step();
      total++;
      if (bus.O_MEM_READ !== 1'b1 || bus.O_MEM_ADDRESS !== 16'hFFFE) begin
         bad++; $display("FAIL prio_reissue: read=%b addr=%h, required 1 fffe", bus.O_MEM_READ, bus.O_MEM_ADDRESS);
      end
      step();
      step();
      total++;
      if (inc_pulses != inc0 || redir_pulses != red0 + 1) begin
         bad++; $display("FAIL prio_counts: inc=%0d redir=%0d, required 0 1", inc_pulses - inc0, redir_pulses - red0);
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      do_reset();
      wait_valid("rstmid");
      p0 = inc_pulses + redir_pulses;
      nreset = 1'b0;
      #1;
      total++;
      if ({bus.O_INSTR_VALID, bus.O_PC_ENABLE, bus.O_MEM_READ} !== 3'b0 || bus.O_INSTR !== 16'h0) begin
         bad++; $display("FAIL rstmid_abort: valid=%b en=%b read=%b instr=%h, required 0 0 0 0000",
                         bus.O_INSTR_VALID, bus.O_PC_ENABLE, bus.O_MEM_READ, bus.O_INSTR);
      end
      step();
      step();
      nreset = 1'b1;
      total++;
      if (bus.O_MEM_READ !== 1'b0) begin
         bad++; $display("FAIL rstmid_idle: read=%b, required 0", bus.O_MEM_READ);
      end
      step();
      total++;
      if (bus.O_MEM_READ !== 1'b1 || bus.O_MEM_ADDRESS !== 16'h0000) begin
         bad++; $display("FAIL rstmid_restart: read=%b addr=%h, required 1 0000", bus.O_MEM_READ, bus.O_MEM_ADDRESS);
      end
      total++;
      if (inc_pulses + redir_pulses != p0) begin
         bad++; $display("FAIL rstmid_no_pulse: %0d pulses, required 0", inc_pulses + redir_pulses - p0);
      end
   endtask

`ifdef CR16_FETCH_STALL_COUNT_EN
   task automatic test_stall_saturate();
      do_reset();
      wait_valid("sat");
      force dut.stall_count_q = 16'hFFFF;
      #1;
      release dut.stall_count_q;
      step();
      total++;
      if (bus.O_STALL_COUNT !== 16'hFFFF) begin
         bad++; $display("FAIL stall_saturate: got %h, required ffff", bus.O_STALL_COUNT);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i * 7);
      mem[0] = 16'h1234;
      bus.I_INSTR_READY = 1'b0;
      bus.I_REDIRECT = 1'b0;
      bus.I_REDIRECT_ADDRESS = 16'h0000;
      bus.I_REDIRECT_DISPLACE = 1'b0;
      test_reset();
      test_first_fetch();
      test_back_to_back();
      test_stall();
      test_redirect_capture();
      test_redirect_priority();
      test_reset_mid();
`ifdef CR16_FETCH_STALL_COUNT_EN
      test_stall_saturate();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
